alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue/writeback stage for the 4-bit ALU. Accepts {opcode, B} commands
//  over a valid/ready handshake and drives the ALU from an internal accumulator (A).
//  Waits a fixed ALU latency, then captures Out/Z/C and returns them on a
//  valid/ready result port. Non-compare results are written back to the accumulator.
//  Sits between the pin-level input decode and the ALU; the parent instantiates both.
// PARAMETERS
//  WIDTH    4  datapath width (accumulator, B, ALU result)
//  ALU_LAT  1  cycles operands are held stable before the ALU result is sampled (>=1)
//  ACC_WB   1  1 = write ALU result back to accumulator for opcodes 0000..1011
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous reset, active high
//  in_valid     in   1      command valid
//  in_ready     out  1      command accepted when in_valid & in_ready
//  in_load      in   1      1 = load accumulator with in_b; no ALU operation
//  in_clear     in   1      clear accumulator (IDLE only)
//  in_opcode    in   4      ALU opcode
//  in_b         in   WIDTH  B operand / load value
//  alu_a        out  WIDTH  to ALU A (accumulator)
//  alu_b        out  WIDTH  to ALU B (registered)
//  alu_opcode   out  4      to ALU Opcode (registered)
//  alu_out      in   WIDTH  from ALU Out
//  alu_z        in   1      from ALU Z
//  alu_c        in   1      from ALU C
//  res_valid    out  1      result valid
//  res_ready    in   1      result consumed when res_valid & res_ready
//  res_data     out  WIDTH  captured result
//  res_z        out  1      captured zero flag
//  res_c        out  1      captured carry flag
//  acc          out  WIDTH  current accumulator value
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; acc, alu_b, alu_opcode, res_data, res_z, res_c = 0;
//   res_valid = 0; in_ready = 1 once rst deasserts. Reset mid-operation drops the command.
//  alu_a = acc; alu_b/alu_opcode are registers, stable for all EXEC cycles.
//  FSM: IDLE -> EXEC -> RESP -> IDLE (load path: IDLE -> RESP).
//   IDLE: in_ready = ~in_clear. in_clear=1: acc<=0, no command accepted that cycle.
//    Accept (in_valid & in_ready): in_load=1 -> acc<=in_b, res_data<=in_b,
//    res_z<=(in_b==0), res_c<=0, go RESP. Else alu_opcode<=in_opcode, alu_b<=in_b,
//    cnt<=ALU_LAT-1, go EXEC.
//   EXEC: in_ready=0. cnt!=0: cnt--. cnt==0: res_data<=alu_out, res_z<=alu_z,
//    res_c<=alu_c; if ACC_WB and alu_opcode<4'b1100, acc<=alu_out; go RESP.
//   RESP: res_valid=1, in_ready=0; outputs held until res_ready; then IDLE.
//  Latency: command accepted at edge T -> res_valid high in cycle T+ALU_LAT+1; load
//   command -> res_valid in cycle T+1. Max throughput: one op per ALU_LAT+2 cycles.
//  in_valid/in_clear outside IDLE: ignored. Compare opcodes 1100..1111 never modify acc.
//  Arithmetic is entirely in the ALU; this block adds no carry-in and no width extension.
//  res_ready held high: res_valid high exactly one cycle per command.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_SHL..OP_LT), OP_CMP_BASE=4'b1100,
//   FSM state encoding (IDLE/EXEC/RESP, 2-bit). No sub-module; ALU not instantiated here.
// TESTING
//  1 Reset: rst=1 mid-EXEC -> next cycle state IDLE, acc=0, res_valid=0, in_ready=1.
//  2 load B=7, then ADD(0100) B=9 -> res_data=0, res_z=1, res_c=1, acc=0.
//  3 load 5, SUB(0110) B=3 -> res_data=2, res_c=1, res_z=0, acc=2.
//  4 acc=2, GT(1110) B=1 -> res_data=1, res_z=0; acc stays 2.
//  5 ALU_LAT=3: accept at T -> res_valid first high at T+4; alu_b/opcode stable T+1..T+3.
//  6 res_ready=0 for 5 cycles -> res_valid/res_data stable, in_ready=0;
//    in_clear with in_valid in IDLE -> acc=0, command not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its issue/writeback sequencer:
// opcode map, compare-group boundary and sequencer FSM encoding.
package alu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_SHL = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SHR = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ROL = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ROR = 4'b0011;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OPC_W-1:0] OP_INC = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OPC_W-1:0] OP_DEC = 4'b0111;
  localparam logic [OPC_W-1:0] OP_AND = 4'b1000;
  localparam logic [OPC_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_XOR = 4'b1010;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b1011;
  localparam logic [OPC_W-1:0] OP_EQ  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_NE  = 4'b1101;
  localparam logic [OPC_W-1:0] OP_GT  = 4'b1110;
  localparam logic [OPC_W-1:0] OP_LT  = 4'b1111;

  // Opcodes at or above this value are compares and never update the accumulator.
  localparam logic [OPC_W-1:0] OP_CMP_BASE = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_cmp(input logic [OPC_W-1:0] op);
    return op >= OP_CMP_BASE;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-operand and result bundle of the ALU op sequencer.
// master = surrounding logic (command source, ALU, result sink); slave = sequencer.
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic             in_clear;
  logic [OPC_W-1:0] in_opcode;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPC_W-1:0] alu_opcode;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_c;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_z;
  logic             res_c;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, in_load, in_clear, in_opcode, in_b,
    output alu_out, alu_z, alu_c, res_ready,
    input  in_ready, alu_a, alu_b, alu_opcode,
    input  res_valid, res_data, res_z, res_c, acc
  );

  modport slave (
    input  in_valid, in_load, in_clear, in_opcode, in_b,
    input  alu_out, alu_z, alu_c, res_ready,
    output in_ready, alu_a, alu_b, alu_opcode,
    output res_valid, res_data, res_z, res_c, acc
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/writeback stage for the 4-bit ALU: holds the accumulator, presents
// registered operands for ALU_LAT cycles, then captures and returns the result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1,
  parameter bit ACC_WB  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [OPC_W-1:0] opcode_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_z_q;
  logic             res_c_q;
  logic             in_ready_w;

  // A clear request blocks acceptance in the same cycle it zeroes the accumulator.
  assign in_ready_w = (state == ST_IDLE) && !bus.in_clear && !rst;

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; a blocking = here would chain updates in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      opcode_q   <= '0;
      res_data_q <= '0;
      res_z_q    <= 1'b0;
      res_c_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_clear) begin
            acc_q <= '0;
          end else if (bus.in_valid && in_ready_w) begin
            if (bus.in_load) begin
              acc_q      <= bus.in_b;
              res_data_q <= bus.in_b;
              res_z_q    <= (bus.in_b == '0);
              res_c_q    <= 1'b0;
              state      <= ST_RESP;
            end else begin
              opcode_q <= bus.in_opcode;
              b_q      <= bus.in_b;
              cnt      <= CNT_W'(ALU_LAT - 1);
              state    <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_data_q <= bus.alu_out;
            res_z_q    <= bus.alu_z;
            res_c_q    <= bus.alu_c;
            if (ACC_WB && !is_cmp(opcode_q)) acc_q <= bus.alu_out;
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.res_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.res_valid  = (state == ST_RESP);
  assign bus.res_data   = res_data_q;
  assign bus.res_z      = res_z_q;
  assign bus.res_c      = res_c_q;
  assign bus.acc        = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, multi-cycle corner sequences and
// random commands checked against a command-level reference model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] out;
    logic       z;
    logic       c;
  } alu_res_t;

  typedef struct {
    logic       load;
    logic [3:0] op;
    logic [3:0] b;
    logic [3:0] data;
    logic       z;
    logic       c;
    logic [3:0] acc;
  } vec_t;

  alu_op_sequencer_if #(.WIDTH(4)) bus1 ();
  alu_op_sequencer_if #(.WIDTH(4)) bus3 ();

  alu_op_sequencer #(.WIDTH(4), .ALU_LAT(1), .ACC_WB(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  alu_op_sequencer #(.WIDTH(4), .ALU_LAT(3), .ACC_WB(1'b1)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // Behaviour of the 4-bit ALU that sits behind the sequencer.
  function automatic alu_res_t alu_ref(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    alu_res_t   r;
    logic [4:0] w;
    r.c = 1'b0;
    w   = 5'd0;
    case (op)
      OP_SHL: begin r.out = {a[2:0], 1'b0}; r.c = a[3]; end
      OP_SHR: begin r.out = {1'b0, a[3:1]}; r.c = a[0]; end
      OP_ROL: begin r.out = {a[2:0], a[3]}; r.c = a[3]; end
      OP_ROR: begin r.out = {a[0], a[3:1]}; r.c = a[0]; end
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r.out = w[3:0]; r.c = w[4]; end
      OP_INC: begin w = {1'b0, a} + 5'd1; r.out = w[3:0]; r.c = w[4]; end
      OP_SUB: begin r.out = a - b; r.c = (a >= b); end
      OP_DEC: begin r.out = a - 4'd1; r.c = (a != 4'd0); end
      OP_AND: r.out = a & b;
      OP_OR:  r.out = a | b;
      OP_XOR: r.out = a ^ b;
      OP_NOT: r.out = ~a;
      OP_EQ:  r.out = {3'b000, a == b};
      OP_NE:  r.out = {3'b000, a != b};
      OP_GT:  r.out = {3'b000, a > b};
      default: r.out = {3'b000, a < b};
    endcase
    r.z = (r.out == 4'd0);
    return r;
  endfunction

  // Command-level model: what one accepted command returns and leaves in the accumulator.
  function automatic alu_res_t model_cmd(input logic [3:0] acc, input logic load,
                                         input logic [3:0] op, input logic [3:0] b,
                                         output logic [3:0] acc_next);
    alu_res_t r;
    if (load) begin
      r.out = b; r.z = (b == 4'd0); r.c = 1'b0; acc_next = b;
    end else begin
      r = alu_ref(acc, b, op);
      acc_next = (op >= 4'd12) ? acc : r.out;
    end
    return r;
  endfunction

  alu_res_t alu1, alu3;
  assign alu1 = alu_ref(bus1.alu_a, bus1.alu_b, bus1.alu_opcode);
  assign alu3 = alu_ref(bus3.alu_a, bus3.alu_b, bus3.alu_opcode);
  assign bus1.alu_out = alu1.out;
  assign bus1.alu_z   = alu1.z;
  assign bus1.alu_c   = alu1.c;
  assign bus3.alu_out = alu3.out;
  assign bus3.alu_z   = alu3.z;
  assign bus3.alu_c   = alu3.c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on dut1; holds res_ready low for 'stall' cycles while
  // poking in_valid/in_clear, which must be ignored outside IDLE.
  task automatic run_cmd(input logic load, input logic [3:0] op, input logic [3:0] b,
                         input int stall, output logic [3:0] data, output logic z,
                         output logic c, output logic [3:0] acc_o, output int lat);
    bus1.in_valid  = 1'b1;
    bus1.in_load   = load;
    bus1.in_opcode = op;
    bus1.in_b      = b;
    bus1.res_ready = 1'b0;
    #1;
    for (int g = 0; g < 20 && !bus1.in_ready; g++) begin
      @(negedge clk); #1;
    end
    check("accept_ready", bus1.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid  = 1'b0;
    bus1.in_load   = 1'($urandom);
    bus1.in_opcode = 4'($urandom);
    bus1.in_b      = 4'($urandom);
    #1;
    lat = 1;
    while (!bus1.res_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    data  = bus1.res_data;
    z     = bus1.res_z;
    c     = bus1.res_c;
    acc_o = bus1.acc;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_clear = 1'b1;
      #1;
      check("stall_valid", bus1.res_valid, 1'b1);
      check("stall_result", {bus1.res_z, bus1.res_c, bus1.res_data}, {z, c, data});
      check("stall_in_ready", bus1.in_ready, 1'b0);
      check("stall_acc", bus1.acc, acc_o);
    end
    bus1.in_valid  = 1'b0;
    bus1.in_clear  = 1'b0;
    bus1.res_ready = 1'b1;
    @(negedge clk);
    bus1.res_ready = 1'b0;
    #1;
    check("res_consumed", bus1.res_valid, 1'b0);
  endtask

  vec_t       vecs[13];
  logic [3:0] d, a, model_acc, exp_acc;
  logic       z, c, load;
  logic [3:0] op, b;
  int         lat, stall;
  alu_res_t   exp_r;

  initial begin
    //            load  op      b      data   z     c     acc
    vecs[0]  = '{1'b1, OP_SHL, 4'd7,  4'd7,  1'b0, 1'b0, 4'd7};
    vecs[1]  = '{1'b0, OP_ADD, 4'd9,  4'd0,  1'b1, 1'b1, 4'd0};
    vecs[2]  = '{1'b1, OP_SHL, 4'd5,  4'd5,  1'b0, 1'b0, 4'd5};
    vecs[3]  = '{1'b0, OP_SUB, 4'd3,  4'd2,  1'b0, 1'b1, 4'd2};
    vecs[4]  = '{1'b0, OP_GT,  4'd1,  4'd1,  1'b0, 1'b0, 4'd2};
    vecs[5]  = '{1'b1, OP_SHL, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, OP_DEC, 4'd0,  4'd15, 1'b0, 1'b0, 4'd15};
    vecs[7]  = '{1'b0, OP_SHL, 4'd0,  4'd14, 1'b0, 1'b1, 4'd14};
    vecs[8]  = '{1'b0, OP_EQ,  4'd14, 4'd1,  1'b0, 1'b0, 4'd14};
    vecs[9]  = '{1'b0, OP_LT,  4'd3,  4'd0,  1'b1, 1'b0, 4'd14};
    vecs[10] = '{1'b0, OP_XOR, 4'd14, 4'd0,  1'b1, 1'b0, 4'd0};
    vecs[11] = '{1'b0, OP_NOT, 4'd0,  4'd15, 1'b0, 1'b0, 4'd15};
    vecs[12] = '{1'b0, OP_INC, 4'd0,  4'd0,  1'b1, 1'b1, 4'd0};

    rst = 1'b1;
    {bus1.in_valid, bus1.in_load, bus1.in_clear, bus1.res_ready} = 4'b0000;
    bus1.in_opcode = 4'd0; bus1.in_b = 4'd0;
    {bus3.in_valid, bus3.in_load, bus3.in_clear} = 3'b000;
    bus3.res_ready = 1'b1; bus3.in_opcode = 4'd0; bus3.in_b = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_acc", bus1.acc, 4'd0);
    check("rst_res_valid", bus1.res_valid, 1'b0);
    check("rst_in_ready", bus1.in_ready, 1'b1);
    check("rst_result", {bus1.res_z, bus1.res_c, bus1.res_data}, 6'd0);

    // Reset in the middle of EXEC drops the command immediately.
    run_cmd(1'b1, OP_SHL, 4'd5, 0, d, z, c, a, lat);
    check("t1_load_acc", a, 4'd5);
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_load = 1'b0; bus1.in_opcode = OP_ADD; bus1.in_b = 4'd3;
    #1;
    check("t1_in_ready", bus1.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    check("t1_in_exec", bus1.res_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("t1_async_acc", bus1.acc, 4'd0);
    check("t1_async_res_data", bus1.res_data, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_in_ready_after", bus1.in_ready, 1'b1);
    check("t1_res_valid_after", bus1.res_valid, 1'b0);
    check("t1_alu_b_op", {bus1.alu_b, bus1.alu_opcode}, 8'h00);
    @(negedge clk); #1;
    check("t1_dropped", bus1.res_valid, 1'b0);

    // Directed vectors, result consumed immediately.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].load, vecs[i].op, vecs[i].b, 0, d, z, c, a, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_z", i), z, vecs[i].z);
      check($sformatf("vec%0d_c", i), c, vecs[i].c);
      check($sformatf("vec%0d_acc", i), a, vecs[i].acc);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].load ? 1 : 2);
    end

    // ALU_LAT=3: operands held three cycles, result visible in the fourth.
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.in_load = 1'b1; bus3.in_b = 4'd5;
    #1;
    check("t5_load_ready", bus3.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    #1;
    check("t5_load_valid", bus3.res_valid, 1'b1);
    check("t5_load_acc", bus3.acc, 4'd5);
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.in_load = 1'b0; bus3.in_opcode = OP_ADD; bus3.in_b = 4'd3;
    #1;
    check("t5_op_ready", bus3.in_ready, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus3.in_valid = 1'b0; bus3.in_opcode = 4'($urandom); bus3.in_b = 4'($urandom);
      #1;
      check($sformatf("t5_exec%0d_valid", k), bus3.res_valid, 1'b0);
      check($sformatf("t5_exec%0d_operands", k),
            {bus3.alu_a, bus3.alu_b, bus3.alu_opcode}, {4'd5, 4'd3, OP_ADD});
    end
    @(negedge clk); #1;
    check("t5_resp_valid", bus3.res_valid, 1'b1);
    check("t5_resp_result", {bus3.res_z, bus3.res_c, bus3.res_data}, {1'b0, 1'b0, 4'd8});
    check("t5_resp_acc", bus3.acc, 4'd8);
    @(negedge clk); #1;
    check("t5_one_cycle", bus3.res_valid, 1'b0);

    // Held result under back-pressure, then a clear that blocks a command.
    run_cmd(1'b1, OP_SHL, 4'd6, 5, d, z, c, a, lat);
    check("t6_data", d, 4'd6);
    check("t6_acc", a, 4'd6);
    bus1.in_valid = 1'b1; bus1.in_load = 1'b1; bus1.in_b = 4'd9; bus1.in_clear = 1'b1;
    #1;
    check("t6_clear_ready", bus1.in_ready, 1'b0);
    @(negedge clk);
    bus1.in_valid = 1'b0; bus1.in_clear = 1'b0;
    #1;
    check("t6_clear_acc", bus1.acc, 4'd0);
    check("t6_clear_no_cmd", bus1.res_valid, 1'b0);
    @(negedge clk); #1;
    check("t6_clear_no_cmd2", bus1.res_valid, 1'b0);

    // Random commands against the reference model.
    model_acc = 4'd0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus1.in_clear = 1'b1; bus1.in_valid = 1'($urandom); bus1.in_load = 1'($urandom);
        #1;
        check("rnd_clear_ready", bus1.in_ready, 1'b0);
        @(negedge clk);
        bus1.in_clear = 1'b0; bus1.in_valid = 1'b0;
        #1;
        check("rnd_clear_acc", bus1.acc, 4'd0);
        model_acc = 4'd0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      load  = ($urandom_range(0, 3) == 0);
      op    = 4'($urandom);
      b     = 4'($urandom);
      stall = $urandom_range(0, 3);
      exp_r = model_cmd(model_acc, load, op, b, exp_acc);
      run_cmd(load, op, b, stall, d, z, c, a, lat);
      check($sformatf("rnd%0d_result", n), {z, c, d}, {exp_r.z, exp_r.c, exp_r.out});
      check($sformatf("rnd%0d_acc", n), a, exp_acc);
      check($sformatf("rnd%0d_latency", n), lat, load ? 1 : 2);
      model_acc = exp_acc;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
